// File: rtl/video_timing_pkg.sv
// Shared raster timing defaults, counter widths and the frame-lock state type
// for the line-doubled VGA output path.
package video_timing_pkg;
  localparam int CNT_W  = 11;
  localparam int PIX_W  = 9;
  localparam int ADDR_W = PIX_W + 1;

  localparam int DEF_H_ACTIVE = 512;
  localparam int DEF_H_TOTAL  = 682;
  localparam int DEF_HS_START = 570;
  localparam int DEF_HS_WIDTH = 80;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_TOTAL  = 524;
  localparam int DEF_VS_START = 490;
  localparam int DEF_VS_WIDTH = 2;
  localparam int DEF_LOCK_TOL = 4;
  localparam int DEF_MISS_MAX = 3;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ALIGN    = 2'd1,
    LOCKED   = 2'd2
  } state_e;
endpackage

// File: rtl/video_hv_counter.sv
// Raster h/v counters with a force-to-zero input (frame alignment) and a
// realign input that sends vcount to 0 at the next line wrap.
module video_hv_counter
  import video_timing_pkg::*;
#(
  parameter int H_TOTAL = DEF_H_TOTAL,
  parameter int V_TOTAL = DEF_V_TOTAL
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             force_zero_i,
  input  logic             realign_i,
  output logic [CNT_W-1:0] hcount_o,
  output logic [CNT_W-1:0] vcount_o,
  output logic [CNT_W-1:0] h_next_o,
  output logic [CNT_W-1:0] v_next_o,
  output logic [CNT_W-1:0] v_wrap_o,
  output logic             hend_o
);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic [CNT_W-1:0] v_wrap;
  logic             hend, vend;

  assign hend = (hcount_q == H_LAST);
  assign vend = (vcount_q == V_LAST);
  // Line number the raster moves to when the current line ends.
  assign v_wrap = (realign_i || vend) ? '0 : vcount_q + CNT_W'(1);

  always_comb begin
    hcount_d = hend ? '0 : hcount_q + CNT_W'(1);
    vcount_d = hend ? v_wrap : vcount_q;
    if (force_zero_i) begin
      hcount_d = '0;
      vcount_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign hcount_o = hcount_q;
  assign vcount_o = vcount_q;
  assign h_next_o = hcount_d;
  assign v_next_o = vcount_d;
  assign v_wrap_o = v_wrap;
  assign hend_o   = hend;
endmodule

// File: rtl/video_scan_scheduler.sv
// VGA raster sequencer for the scan doubler, frame-locked to the PPU.
// Optional scanline dimming output is enabled with `define VIDEO_SCANLINE_EN.
module video_scan_scheduler
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_WIDTH = DEF_HS_WIDTH,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int VS_START = DEF_VS_START,
  parameter int VS_WIDTH = DEF_VS_WIDTH,
  parameter int LOCK_TOL = DEF_LOCK_TOL,
  parameter int MISS_MAX = DEF_MISS_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              src_frame_start,
`ifdef VIDEO_SCANLINE_EN
  input  logic              scanlines_on,
  output logic              dim,
`endif
  output logic [CNT_W-1:0]  hcount,
  output logic [CNT_W-1:0]  vcount,
  output logic              hs,
  output logic              vs,
  output logic              blank,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              line_req,
  output logic              locked
);
  localparam logic [CNT_W-1:0] HA_C   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS0_C  = CNT_W'(HS_START);
  localparam logic [CNT_W-1:0] HS1_C  = CNT_W'(HS_START + HS_WIDTH);
  localparam logic [CNT_W-1:0] VA_C   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS0_C  = CNT_W'(VS_START);
  localparam logic [CNT_W-1:0] VS1_C  = CNT_W'(VS_START + VS_WIDTH);
  localparam logic [CNT_W-1:0] TOL_LO = CNT_W'(LOCK_TOL);
  localparam logic [CNT_W-1:0] TOL_HI = CNT_W'(V_TOTAL - LOCK_TOL);
  localparam int               MISS_W = $clog2(MISS_MAX + 1);
  localparam logic [MISS_W-1:0] MISS_LIM = MISS_W'(MISS_MAX);
  localparam int               WD_W   = $clog2(2 * V_TOTAL + 1);
  localparam logic [WD_W-1:0]  WD_LIM = WD_W'(2 * V_TOTAL);

  state_e            state_q, state_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              realign_q, realign_d;
  logic              hs_q, vs_q, blank_q, rd_en_q;
  logic              hs_d, vs_d, blank_d;
  logic [CNT_W-1:0]  h_next, v_next, v_wrap;
  logic              hend, in_window;
  logic [PIX_W-1:0]  pix_idx;

  video_hv_counter #(.H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL)) u_hv (
    .clk_i        (clk),
    .reset_i      (reset),
    .force_zero_i (state_q == ALIGN),
    .realign_i    (realign_q && (state_q == LOCKED)),
    .hcount_o     (hcount),
    .vcount_o     (vcount),
    .h_next_o     (h_next),
    .v_next_o     (v_next),
    .v_wrap_o     (v_wrap),
    .hend_o       (hend)
  );

  // Window check uses the current (pre-increment) line.
  assign in_window = (vcount < TOL_LO) || (vcount >= TOL_HI);

  always_comb begin
    state_d   = state_q;
    miss_d    = miss_q;
    wd_d      = wd_q;
    realign_d = hend ? 1'b0 : realign_q;
    unique case (state_q)
      UNLOCKED: begin
        miss_d    = '0;
        wd_d      = '0;
        realign_d = 1'b0;
        if (src_frame_start) state_d = ALIGN;
      end
      ALIGN: begin
        miss_d    = '0;
        wd_d      = '0;
        realign_d = 1'b0;
        state_d   = LOCKED;
      end
      LOCKED: begin
        if (hend) wd_d = wd_q + WD_W'(1);
        if (src_frame_start) begin
          wd_d = '0;
          if (in_window) begin
            miss_d = '0;
            if (vcount != '0) realign_d = 1'b1;
          end else begin
            miss_d = miss_q + MISS_W'(1);
            if (miss_d == MISS_LIM) state_d = UNLOCKED;
          end
        end
        if (wd_d == WD_LIM) state_d = UNLOCKED;
      end
      default: state_d = UNLOCKED;
    endcase
  end

  // Registered syncs decode the next counter values so they line up with hcount/vcount.
  assign hs_d    = !((h_next >= HS0_C) && (h_next < HS1_C));
  assign vs_d    = !((v_next >= VS0_C) && (v_next < VS1_C));
  assign blank_d = !((h_next < HA_C) && (v_next < VA_C));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= UNLOCKED;
      miss_q    <= '0;
      wd_q      <= '0;
      realign_q <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_q   <= 1'b1;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      miss_q    <= miss_d;
      wd_q      <= wd_d;
      realign_q <= realign_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_q   <= blank_d;
      rd_en_q   <= !blank_d;
    end
  end

`ifdef VIDEO_SCANLINE_EN
  logic dim_q;
  always_ff @(posedge clk) begin
    if (reset) dim_q <= 1'b0;
    else       dim_q <= scanlines_on && !blank_d && v_next[0];
  end
  assign dim = dim_q;
`endif

  // Fetch one pixel ahead; index folds to 0 once past the 512-pixel buffer.
  assign pix_idx  = hcount[PIX_W] ? '0 : hcount[PIX_W-1:0] + PIX_W'(1);
  assign rd_addr  = {vcount[0], pix_idx};
  assign line_req = hend && (v_wrap < VA_C) && !v_wrap[0];
  assign hs       = hs_q;
  assign vs       = vs_q;
  assign blank    = blank_q;
  assign rd_en    = rd_en_q;
  assign locked   = (state_q == LOCKED);
endmodule

// File: tb/tb_video_scan_scheduler.sv
// Bench for video_scan_scheduler: a full-size instance for line-level timing and
// a shrunken-raster instance for frame lock, both checked against a behavioural model.
module tb_video_scan_scheduler;
  typedef struct packed {
    int ha; int ht; int hss; int hsw; int va; int vt; int vss; int vsw; int tol; int mm; int scan;
  } cfg_t;

  typedef struct packed {
    int h; int v; int st; int miss; int wd; int realign;
    bit hs; bit vs; bit blank; bit rd_en; bit dim;
  } mdl_t;

  localparam cfg_t CA = '{ha:512, ht:682, hss:570, hsw:80, va:480, vt:524, vss:490, vsw:2,
                          tol:4, mm:3, scan:0};
  localparam cfg_t CB = '{ha:20, ht:32, hss:24, hsw:4, va:20, vt:26, vss:22, vsw:2,
                          tol:3, mm:3, scan:1};

  logic clk = 1'b0;
  logic rst_a = 1'b1, sfs_a = 1'b0, rst_b = 1'b1, sfs_b = 1'b0;
  logic [10:0] hc_a, vc_a, hc_b, vc_b;
  logic hs_a, vs_a, bl_a, re_a, lr_a, lk_a;
  logic hs_b, vs_b, bl_b, re_b, lr_b, lk_b;
  logic [9:0] ra_a, ra_b;
  logic en_a = 1'b0, en_b = 1'b0;
  mdl_t ma, mb;
  int n_checks = 0;
  int n_errors = 0;

`ifdef VIDEO_SCANLINE_EN
  logic dim_a, dim_b;
  logic scan_a = 1'b0, scan_b = 1'b1;
`endif

  always #5 clk = ~clk;

  video_scan_scheduler dut_a (
    .clk(clk), .reset(rst_a), .src_frame_start(sfs_a),
`ifdef VIDEO_SCANLINE_EN
    .scanlines_on(scan_a), .dim(dim_a),
`endif
    .hcount(hc_a), .vcount(vc_a), .hs(hs_a), .vs(vs_a), .blank(bl_a), .rd_en(re_a),
    .rd_addr(ra_a), .line_req(lr_a), .locked(lk_a)
  );

  video_scan_scheduler #(
    .H_ACTIVE(20), .H_TOTAL(32), .HS_START(24), .HS_WIDTH(4), .V_ACTIVE(20), .V_TOTAL(26),
    .VS_START(22), .VS_WIDTH(2), .LOCK_TOL(3), .MISS_MAX(3)
  ) dut_b (
    .clk(clk), .reset(rst_b), .src_frame_start(sfs_b),
`ifdef VIDEO_SCANLINE_EN
    .scanlines_on(scan_b), .dim(dim_b),
`endif
    .hcount(hc_b), .vcount(vc_b), .hs(hs_b), .vs(vs_b), .blank(bl_b), .rd_en(re_b),
    .rd_addr(ra_b), .line_req(lr_b), .locked(lk_b)
  );

  // Line the raster will show after the current one ends (realign only acts while locked).
  function automatic int next_line(input mdl_t m, input cfg_t c);
    if (m.st == 2 && m.realign != 0) return 0;
    return (m.v == c.vt - 1) ? 0 : m.v + 1;
  endfunction

  function automatic mdl_t step(input mdl_t m, input cfg_t c, input bit rst, input bit sfs);
    mdl_t n = m;
    bit wrap = (m.h == c.ht - 1);
    if (rst) begin
      n = '0;
      n.hs = 1'b1; n.vs = 1'b1; n.blank = 1'b1;
      return n;
    end
    if (m.st == 1) begin
      n.h = 0; n.v = 0;
    end else begin
      n.h = wrap ? 0 : m.h + 1;
      n.v = wrap ? next_line(m, c) : m.v;
    end
    if (m.st != 2) begin
      n.miss = 0; n.wd = 0; n.realign = 0;
      n.st = (m.st == 1) ? 2 : (sfs ? 1 : 0);
    end else begin
      if (wrap) begin n.realign = 0; n.wd = m.wd + 1; end
      if (sfs) begin
        n.wd = 0;
        if (m.v < c.tol || m.v >= c.vt - c.tol) begin
          n.miss = 0;
          if (m.v != 0) n.realign = 1;
        end else begin
          n.miss = m.miss + 1;
          if (n.miss >= c.mm) n.st = 0;
        end
      end
      if (n.wd >= 2 * c.vt) n.st = 0;
    end
    n.hs    = !(n.h >= c.hss && n.h < c.hss + c.hsw);
    n.vs    = !(n.v >= c.vss && n.v < c.vss + c.vsw);
    n.blank = !(n.h < c.ha && n.v < c.va);
    n.rd_en = !n.blank;
    n.dim   = (c.scan != 0) && !n.blank && (n.v % 2 == 1);
    return n;
  endfunction

  function automatic logic [37:0] pk(input logic [10:0] h, input logic [10:0] v,
                                     input logic hs, input logic vs, input logic bl,
                                     input logic re, input logic [9:0] ra,
                                     input logic lr, input logic lk);
    return {h, v, hs, vs, bl, re, ra, lr, lk};
  endfunction

  function automatic logic [37:0] model_vec(input mdl_t m, input cfg_t c);
    int idx = (m.h < 511) ? m.h + 1 : 0;
    int nl  = next_line(m, c);
    bit lr  = (m.h == c.ht - 1) && (nl < c.va) && (nl % 2 == 0);
    return pk(11'(m.h), 11'(m.v), m.hs, m.vs, m.blank, m.rd_en,
              10'((m.v % 2) * 512 + idx), lr, m.st == 2);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_b();
    sfs_b = 1'b1;
    ticks(1);
    sfs_b = 1'b0;
  endtask

  always @(posedge clk) begin
    ma <= step(ma, CA, rst_a, sfs_a);
    mb <= step(mb, CB, rst_b, sfs_b);
    if (rst_a) en_a <= 1'b1;
    if (rst_b) en_b <= 1'b1;
  end

  always @(negedge clk) begin
    if (en_a) chk("a_cycle", 64'(pk(hc_a, vc_a, hs_a, vs_a, bl_a, re_a, ra_a, lr_a, lk_a)),
                  64'(model_vec(ma, CA)));
    if (en_b) chk("b_cycle", 64'(pk(hc_b, vc_b, hs_b, vs_b, bl_b, re_b, ra_b, lr_b, lk_b)),
                  64'(model_vec(mb, CB)));
`ifdef VIDEO_SCANLINE_EN
    if (en_a) chk("a_dim", 64'(dim_a), 64'(ma.dim));
    if (en_b) chk("b_dim", 64'(dim_b), 64'(mb.dim));
`endif
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    fork
      begin : thread_a
        int hs_cnt = 0;
        int hs_first = -1;
        ticks(2);
        chk("a_reset", 64'(pk(hc_a, vc_a, hs_a, vs_a, bl_a, re_a, ra_a, lr_a, lk_a)),
            64'(pk(11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd1, 1'b0, 1'b0)));
        rst_a = 1'b0;
        for (int p = 1; p <= 681; p++) begin
          ticks(1);
          if (hs_a == 1'b0) begin
            if (hs_first < 0) hs_first = p;
            hs_cnt++;
          end
        end
        chk("a_h681", 64'(hc_a), 64'd681);
        chk("a_hs_start", 64'(hs_first), 64'd570);
        chk("a_hs_len", 64'(hs_cnt), 64'd80);
        ticks(1);
        chk("a_hwrap", 64'({hc_a, vc_a}), 64'({11'd0, 11'd1}));
        ticks(5 * 682 + 681 - 682);
        chk("a_lreq_v5", 64'(lr_a), 64'd1);
        ticks(682);
        chk("a_lreq_v6", 64'(lr_a), 64'd0);
        ticks(1);
        chk("a_addr_v7_h0", 64'(ra_a), 64'h201);
        ticks(510);
        chk("a_addr_h510", 64'(ra_a), 64'h3ff);
        ticks(1);
        chk("a_addr_h511", 64'(ra_a), 64'h200);
        chk("a_locked", 64'(lk_a), 64'd0);
      end
      begin : thread_b
        ticks(2);
        chk("b_reset", 64'(pk(hc_b, vc_b, hs_b, vs_b, bl_b, re_b, ra_b, lr_b, lk_b)),
            64'(pk(11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd1, 1'b0, 1'b0)));
        rst_b = 1'b0;
        ticks(17 * 32 + 31);
        chk("b_lreq_v17", 64'(lr_b), 64'd1);
        ticks(64);
        chk("b_lreq_vlast", 64'(lr_b), 64'd0);
        ticks(831 - 639);
        chk("b_vlast", 64'({hc_b, vc_b}), 64'({11'd31, 11'd25}));
        ticks(1);
        chk("b_vwrap", 64'({hc_b, vc_b, lk_b}), 64'({11'd0, 11'd0, 1'b0}));
        // acquire lock from the middle of the frame
        ticks(10 * 32 + 3);
        pulse_b();
        chk("b_align_lk", 64'(lk_b), 64'd0);
        ticks(1);
        chk("b_acquire", 64'({hc_b, vc_b, lk_b}), 64'({11'd0, 11'd0, 1'b1}));
        // in-window early pulse: realign
        ticks(24 * 32 + 5);
        pulse_b();
        ticks(25);
        chk("b_realign_lreq", 64'({vc_b, lr_b}), 64'({11'd24, 1'b1}));
        ticks(1);
        chk("b_realign_v0", 64'({hc_b, vc_b, lk_b}), 64'({11'd0, 11'd0, 1'b1}));
        ticks(32);
        chk("b_realign_v1", 64'(vc_b), 64'd1);
        // three out-of-window pulses
        ticks(11 * 32);
        pulse_b();
        chk("b_miss1", 64'(lk_b), 64'd1);
        ticks(831);
        pulse_b();
        chk("b_miss2", 64'(lk_b), 64'd1);
        ticks(831);
        pulse_b();
        chk("b_miss3", 64'({hc_b, vc_b, lk_b}), 64'({11'd1, 11'd12, 1'b0}));
        ticks(31);
        chk("b_freerun", 64'({hc_b, vc_b, lk_b}), 64'({11'd0, 11'd13, 1'b0}));
        // relock, then withhold pulses until the watchdog fires
        pulse_b();
        ticks(1);
        chk("b_relock", 64'(lk_b), 64'd1);
        ticks(52 * 32 - 1);
        chk("b_wd_before", 64'({hc_b, vc_b, lk_b}), 64'({11'd31, 11'd25, 1'b1}));
        ticks(1);
        chk("b_wd_after", 64'({hc_b, vc_b, lk_b}), 64'({11'd0, 11'd0, 1'b0}));
        // randomized frame pulses: jittered, short and long gaps, occasional reset
        for (int i = 0; i < 30; i++) begin
          int gap;
          int r = $urandom_range(0, 9);
          if (r < 6)      gap = $urandom_range(832 - 128, 832 + 128);
          else if (r < 8) gap = $urandom_range(1, 400);
          else            gap = $urandom_range(1600, 1800);
          ticks(gap);
          pulse_b();
          if ($urandom_range(0, 14) == 0) begin
            rst_b = 1'b1;
            sfs_b = 1'($urandom_range(0, 1));
            ticks(2);
            rst_b = 1'b0;
            sfs_b = 1'b0;
          end
        end
        ticks(40);
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
